// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract. Both run on
// magnitudes, with the sign fixed up in a final FIX cycle. All outputs are registered.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand (multiply) or divisor (divide), as a magnitude.
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;          // product / quotient is negative
  logic               neg_rem_q, neg_rem_d;  // remainder takes the dividend sign
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes for the signed ops; the unsigned ops pass the operands through.
  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;

  // Datapath for one iteration step and for the final sign fix-up.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand conditioning, one radix-2 step for each operation, and the result sign fix-up.
  always_comb begin
    is_signed = ~op[0];
    a_abs     = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // Shift-add: add the multiplicand when the current multiplier bit is set, then shift right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, then subtract if it fits.
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_diff[WIDTH]) begin
      acc_div = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_div = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    // A zero divisor returns all ones in LO whatever the operand signs.
    quo_fix  = div_zero_q ? {WIDTH{1'b1}} :
               (neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d    = S_CALC;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = op[1];
          neg_d      = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = is_signed & a[WIDTH-1];
          div_zero_d = op[1] & (b == '0);
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_abs};
            opb_d = b_abs;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_abs};
            opb_d = a_abs;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = is_div_q ? acc_div : acc_mul;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; the asynchronous reset aborts any in-flight operation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table for the arithmetic, plus hand-written
// sequences for MTHI/MTLO, start-while-busy, flush and asynchronous reset.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LATENCY = W + 2;  // edges from the start edge up to the done edge, inclusive

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         flush, mthi, mtlo;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(clk), .nRST(nrst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an operation and wait (bounded) for done; returns edge count and busy behaviour.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output bit busy_ok);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    int  lat;
    bit  bok;

    vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_m3x7",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{"mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{"div_m7d2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"divu_7d2",    OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{"div_7dm2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{"div_minm1",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{"divu_5d0",    OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[8]  = '{"div_m7d0",    OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{"div_m8dm3",   OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    vecs[10] = '{"multu_shift", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[11] = '{"mult_m1m1",   OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    nrst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    tick();
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    nrst = 1'b1;
    tick();

    // Arithmetic table, including the divide-by-zero and overflow boundaries.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      $display("op %s: a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h latency=%0d",
               vecs[i].name, vecs[i].a, vecs[i].b, hi, lo, lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(LATENCY));
      check({vecs[i].name, "_busy"}, {63'd0, bok}, 64'd1);
      check({vecs[i].name, "_hilo"}, {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      tick();
      check({vecs[i].name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    end

    // Start while busy is ignored: a second launch at cycle 5 must not disturb the result.
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    $display("restart_ignored: hi=0x%08h lo=0x%08h latency=%0d", hi, lo, lat);
    check("restart_latency", 64'(lat), 64'(LATENCY));
    check("restart_hilo", {hi, lo}, {32'd0, 32'd12});
    tick();

    // MTHI/MTLO in IDLE.
    wdata = 32'h1234; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    wdata = 32'h5678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    $display("mthi/mtlo: hi=0x%08h lo=0x%08h", hi, lo);
    check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});

    // Flush mid-op: second start at cycle 5, MTHI while busy at cycle 7, flush at cycle 10.
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    tick();
    wdata = 32'hDEAD; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    tick();
    tick();
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    bok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bok = 1'b0;
    end
    $display("flush: hi=0x%08h lo=0x%08h quiet=%0d", hi, lo, bok);
    check("flush_quiet", {63'd0, bok}, 64'd1);
    check("flush_hilo_kept", {hi, lo}, {32'h1234, 32'h5678});

    // Flush in IDLE has no effect on a simultaneous MTLO.
    flush = 1'b1; wdata = 32'h0BEE; mtlo = 1'b1;
    tick();
    flush = 1'b0; mtlo = 1'b0;
    check("flush_idle_mtlo", {32'd0, lo}, {32'd0, 32'h0BEE});

    // MTHI coincident with start is applied, then overwritten by the product.
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1; mthi = 1'b1; wdata = 32'hAAAA;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("mthi_with_start", {32'd0, hi}, {32'd0, 32'hAAAA});
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    $display("mthi_with_start: hi=0x%08h lo=0x%08h latency=%0d", hi, lo, lat);
    check("mthi_start_result", {hi, lo}, {32'd0, 32'd12});
    tick();

    // Asynchronous reset in the middle of a DIVU, then a fresh op.
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    #2;
    nrst = 1'b0;
    #1;
    $display("async_reset: busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    check("areset_busy", {62'd0, busy, done}, 64'd0);
    check("areset_hilo", {hi, lo}, 64'd0);
    tick();
    nrst = 1'b1;
    tick();
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bok);
    $display("after_reset divu 100/7: hi=0x%08h lo=0x%08h latency=%0d", hi, lo, lat);
    check("post_reset_latency", 64'(lat), 64'(LATENCY));
    check("post_reset_hilo", {hi, lo}, {32'd2, 32'd14});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
